// File: rtl/tc77_pkg.sv
// Shared definitions for the TC77 temperature sensor reader.
// Contents: frame geometry, the reader FSM state encoding, the signed
// temperature type and the width of the phase timer.
package tc77_pkg;

    localparam int FRAME_W  = 16;
    localparam int TEMP_W   = 13;
    localparam int CONV_BIT = 2;
    localparam int TEMP_MSB = 15;
    localparam int PHASE_W  = 16;

    typedef logic signed [TEMP_W-1:0] temp_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_LOW    = 3'd2,
        ST_HIGH   = 3'd3,
        ST_HOLD   = 3'd4,
        ST_UPDATE = 3'd5,
        ST_WAIT   = 3'd6
    } state_t;

    // States during which the sensor chip select is asserted.
    function automatic logic cs_active(input state_t s);
        return (s == ST_SETUP) || (s == ST_LOW) || (s == ST_HIGH) || (s == ST_HOLD);
    endfunction

endpackage

// File: rtl/tc77_sck_gen.sv
// Phase timer for the TC77 serial clock.
// A down-counter loaded with (phase length - 1); tick is high in the last
// cycle of the phase so the FSM can move on at the following edge.
// Ports:
//   clk      in   system clock
//   rst      in   asynchronous active-high reset
//   load     in   start a new phase this edge
//   load_val in   phase length minus one
//   tick     out  terminal count reached (last cycle of the phase)
import tc77_pkg::*;

module tc77_sck_gen (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [PHASE_W-1:0] load_val,
    output logic               tick
);

    logic [PHASE_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign tick = (cnt == '0);

endmodule

// File: rtl/tc77_reader.sv
// Master side of the TC77 3-wire temperature sensor link. Polls the sensor
// every POLL_CYCLES, shifts in the 16-bit frame and publishes the 13-bit
// signed reading. The block never drives SIO.
// Optional feature: define TC77_OVERTEMP_EN to build the hysteretic
// over-temperature alarm; otherwise overtemp is tied low.
// Ports:
//   mclk         in   system clock
//   rst          in   asynchronous active-high reset
//   enable       in   polling runs while high
//   temp_ncs     out  sensor chip select, active low
//   temp_clk     out  sensor serial clock, idle high
//   temp_sio     in   sensor data (asynchronous, synchronized here)
//   temperature  out  last converted reading, two's complement, 0.0625 C/LSB
//   temp_valid   out  one-cycle pulse when temperature updates
//   temp_ready   out  sticky, set by the first converted reading
//   busy         out  high from chip-select fall through the update cycle
//   overtemp     out  hysteretic alarm (constant 0 unless TC77_OVERTEMP_EN)
//
// state   | meaning
// IDLE    | bus idle, waiting for enable
// SETUP   | chip select low, before first clock fall
// LOW     | serial clock low half period
// HIGH    | serial clock high half period (bit sampled on entry)
// HOLD    | chip select still low after last clock rise
// UPDATE  | chip select released, frame evaluated
// WAIT    | poll interval countdown
import tc77_pkg::*;

module tc77_reader #(
    parameter int               HALF_DIV    = 12,
    parameter int               CS_SETUP    = 4,
    parameter int               CS_HOLD     = 4,
    parameter int               POLL_CYCLES = 24_000_000,
    parameter logic [TEMP_W-1:0] OT_SET     = 13'h0280,
    parameter logic [TEMP_W-1:0] OT_CLR     = 13'h0240
) (
    input  logic              mclk,
    input  logic              rst,
    input  logic              enable,
    output logic              temp_ncs,
    output logic              temp_clk,
    input  logic              temp_sio,
    output logic [TEMP_W-1:0] temperature,
    output logic              temp_valid,
    output logic              temp_ready,
    output logic              busy,
    output logic              overtemp
);

    localparam int POLL_W = $clog2(POLL_CYCLES);

    localparam logic [PHASE_W-1:0] SETUP_LD = PHASE_W'(CS_SETUP - 1);
    localparam logic [PHASE_W-1:0] HALF_LD  = PHASE_W'(HALF_DIV - 1);
    localparam logic [PHASE_W-1:0] HOLD_LD  = PHASE_W'(CS_HOLD - 1);
    // Loaded on chip-select rise so the next frame starts exactly
    // POLL_CYCLES later.
    localparam logic [POLL_W-1:0]  POLL_LD  = POLL_W'(POLL_CYCLES - 1);

    state_t               state, state_nx;
    logic [3:0]           bit_cnt;
    logic [FRAME_W-1:0]   shreg;
    logic                 sio_s1, sio_s2;
    logic [POLL_W-1:0]    poll_cnt;
    logic                 tick;
    logic                 ph_load;
    logic [PHASE_W-1:0]   ph_val;
    logic                 frame_conv;

    assign frame_conv = shreg[CONV_BIT];

    tc77_sck_gen u_sck_gen (
        .clk      (mclk),
        .rst      (rst),
        .load     (ph_load),
        .load_val (ph_val),
        .tick     (tick)
    );

    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            sio_s1 <= 1'b1;
            sio_s2 <= 1'b1;
        end else begin
            sio_s1 <= temp_sio;
            sio_s2 <= sio_s1;
        end
    end

    always_comb begin
        state_nx = state;
        ph_load  = 1'b0;
        ph_val   = '0;
        case (state)
            ST_IDLE: begin
                if (enable) begin
                    state_nx = ST_SETUP;
                    ph_load  = 1'b1;
                    ph_val   = SETUP_LD;
                end
            end
            ST_SETUP: begin
                if (tick) begin
                    state_nx = ST_LOW;
                    ph_load  = 1'b1;
                    ph_val   = HALF_LD;
                end
            end
            ST_LOW: begin
                if (tick) begin
                    state_nx = ST_HIGH;
                    ph_load  = 1'b1;
                    ph_val   = HALF_LD;
                end
            end
            ST_HIGH: begin
                if (tick) begin
                    ph_load = 1'b1;
                    if (bit_cnt == 4'd15) begin
                        state_nx = ST_HOLD;
                        ph_val   = HOLD_LD;
                    end else begin
                        state_nx = ST_LOW;
                        ph_val   = HALF_LD;
                    end
                end
            end
            ST_HOLD: begin
                if (tick) state_nx = ST_UPDATE;
            end
            // enable is only looked at between frames, so a frame in
            // progress always runs to completion.
            ST_UPDATE: state_nx = enable ? ST_WAIT : ST_IDLE;
            ST_WAIT: begin
                if (!enable) begin
                    state_nx = ST_IDLE;
                end else if (poll_cnt == '0) begin
                    state_nx = ST_SETUP;
                    ph_load  = 1'b1;
                    ph_val   = SETUP_LD;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            bit_cnt     <= '0;
            shreg       <= '0;
            poll_cnt    <= '0;
            temp_ncs    <= 1'b1;
            temp_clk    <= 1'b1;
            busy        <= 1'b0;
            temperature <= '0;
            temp_valid  <= 1'b0;
            temp_ready  <= 1'b0;
        end else begin
            state      <= state_nx;
            // Bus pins are registered from the next state so they change
            // cleanly on the same edge as the state.
            temp_ncs   <= !cs_active(state_nx);
            temp_clk   <= (state_nx != ST_LOW);
            busy       <= cs_active(state_nx) || (state_nx == ST_UPDATE);
            temp_valid <= 1'b0;

            if (state_nx == ST_SETUP) bit_cnt <= '0;
            else if (state == ST_HIGH && tick) bit_cnt <= bit_cnt + 1'b1;

            // Sample on the edge that raises the serial clock.
            if (state == ST_LOW && tick) shreg <= {shreg[FRAME_W-2:0], sio_s2};

            if (state == ST_HOLD && tick) poll_cnt <= POLL_LD;
            else if (poll_cnt != '0) poll_cnt <= poll_cnt - 1'b1;

            if (state == ST_UPDATE && frame_conv) begin
                temperature <= shreg[TEMP_MSB -: TEMP_W];
                temp_valid  <= 1'b1;
                temp_ready  <= 1'b1;
            end
        end
    end

`ifdef TC77_OVERTEMP_EN
    temp_t frame_temp;
    assign frame_temp = temp_t'(shreg[TEMP_MSB -: TEMP_W]);

    // Between the thresholds the previous alarm state is kept.
    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            overtemp <= 1'b0;
        end else if (state == ST_UPDATE && frame_conv) begin
            if (frame_temp >= $signed(OT_SET)) overtemp <= 1'b1;
            else if (frame_temp <= $signed(OT_CLR)) overtemp <= 1'b0;
        end
    end
`else
    assign overtemp = 1'b0;
`endif

endmodule

// File: tb/tb_tc77_reader.sv
`timescale 1ns/1ps
module tb_tc77_reader;

    localparam int HALF_DIV  = 12;
    localparam int CS_SETUP  = 4;
    localparam int CS_HOLD   = 4;
    localparam int POLL      = 2000;
    localparam int FRAME_LEN = 32*HALF_DIV + CS_SETUP + CS_HOLD;

`ifdef TC77_OVERTEMP_EN
    localparam bit OT_BUILT = 1'b1;
`else
    localparam bit OT_BUILT = 1'b0;
`endif

    logic        mclk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        temp_sio = 1'b1;
    logic        temp_ncs, temp_clk, temp_valid, temp_ready, busy, overtemp;
    logic [12:0] temperature;

    tc77_reader #(
        .HALF_DIV    (HALF_DIV),
        .CS_SETUP    (CS_SETUP),
        .CS_HOLD     (CS_HOLD),
        .POLL_CYCLES (POLL),
        .OT_SET      (13'h0280),
        .OT_CLR      (13'h0240)
    ) dut (
        .mclk        (mclk),
        .rst         (rst),
        .enable      (enable),
        .temp_ncs    (temp_ncs),
        .temp_clk    (temp_clk),
        .temp_sio    (temp_sio),
        .temperature (temperature),
        .temp_valid  (temp_valid),
        .temp_ready  (temp_ready),
        .busy        (busy),
        .overtemp    (overtemp)
    );

    always #5 mclk = ~mclk;

    // Sensor model: frame latched at chip-select fall, next bit driven
    // 10 ns after each serial clock fall.
    logic [12:0] model_temp = 13'h0;
    logic        model_conv = 1'b0;
    logic [15:0] frame_q = 16'h0;
    int          bit_idx = 0;

    always @(negedge temp_ncs) begin
        frame_q = {model_temp, model_conv, 2'b11};
        bit_idx = 0;
    end

    always @(negedge temp_clk) begin
        if (!temp_ncs) begin
            #10;
            if (bit_idx < 16) temp_sio = frame_q[15-bit_idx];
            bit_idx++;
        end
    end

    always @(posedge temp_ncs) temp_sio = 1'b1;

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Waits for a frame, measures it, and samples temp_valid on the cycle of
    // chip-select rise (early) and one cycle later (late).
    task automatic run_frame(input int drop_bit, output int hi_cycles, output int pulses,
                             output int len, output logic v_early, output logic v_late,
                             output logic busy_mid, output bit ok);
        logic prev;
        hi_cycles = 0; pulses = 0; len = 0; ok = 1'b1;
        v_early = 1'b0; v_late = 1'b0; busy_mid = 1'b0;
        @(negedge mclk);
        while (temp_ncs && hi_cycles < 5000) begin
            hi_cycles++;
            @(negedge mclk);
        end
        if (temp_ncs) begin ok = 1'b0; return; end
        prev = 1'b1;
        while (!temp_ncs && len < 2000) begin
            len++;
            if (prev && !temp_clk) begin
                pulses++;
                if (pulses == drop_bit) enable = 1'b0;
            end
            prev = temp_clk;
            if (len == FRAME_LEN/2) busy_mid = busy;
            @(negedge mclk);
        end
        if (!temp_ncs) begin ok = 1'b0; return; end
        v_early = temp_valid;
        @(negedge mclk);
        v_late = temp_valid;
    endtask

    typedef struct {
        logic [12:0] t;
        logic        conv;
        logic        exp_valid;
        logic [12:0] exp_temp;
        logic        exp_ready;
        logic        exp_ot;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int   hi, pulses, len, fallcnt, guard;
        logic ve, vl, bm, prev, seen_low;
        bit   ok;

        vecs[0] = '{13'h0190, 1'b0, 1'b0, 13'h0000, 1'b0, 1'b0};
        vecs[1] = '{13'h0100, 1'b1, 1'b1, 13'h0100, 1'b1, 1'b0};
        vecs[2] = '{13'h0240, 1'b1, 1'b1, 13'h0240, 1'b1, 1'b0};
        vecs[3] = '{13'h1FF0, 1'b1, 1'b1, 13'h1FF0, 1'b1, 1'b0};
        vecs[4] = '{13'h00AA, 1'b0, 1'b0, 13'h1FF0, 1'b1, 1'b0};
        vecs[5] = '{13'h0280, 1'b1, 1'b1, 13'h0280, 1'b1, 1'b1};
        vecs[6] = '{13'h0260, 1'b1, 1'b1, 13'h0260, 1'b1, 1'b1};
        vecs[7] = '{13'h0000, 1'b0, 1'b0, 13'h0260, 1'b1, 1'b1};
        vecs[8] = '{13'h0240, 1'b1, 1'b1, 13'h0240, 1'b1, 1'b0};

        repeat (3) @(negedge mclk);
        rst = 1'b0;
        @(negedge mclk);
        check("rst_ncs", temp_ncs, 1);
        check("rst_clk", temp_clk, 1);
        check("rst_temp", temperature, 0);
        check("rst_valid", temp_valid, 0);
        check("rst_ready", temp_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_ot", overtemp, 0);

        for (int i = 0; i < 9; i++) begin
            model_temp = vecs[i].t;
            model_conv = vecs[i].conv;
            if (i == 0) enable = 1'b1;
            run_frame(0, hi, pulses, len, ve, vl, bm, ok);
            if (!ok) begin
                check("frame_timeout", 0, 1);
            end else begin
                if (i == 0) check("start_latency", hi, 0);
                else        check("poll_gap", hi + 2, POLL);
                check("clk_pulses", pulses, 16);
                check("frame_len", len, FRAME_LEN);
                check("busy_mid", bm, 1);
                check("valid_early", ve, 0);
                check("valid", vl, vecs[i].exp_valid);
                check("temperature", temperature, vecs[i].exp_temp);
                check("ready", temp_ready, vecs[i].exp_ready);
                check("overtemp", overtemp, OT_BUILT ? vecs[i].exp_ot : 1'b0);
                check("busy_after", busy, 0);
                if (i == 3) check("signed_val", int'($signed(temperature)), -16);
            end
        end

        // enable drops at bit 5: the frame still completes, then idle.
        model_temp = 13'h0123;
        model_conv = 1'b1;
        run_frame(5, hi, pulses, len, ve, vl, bm, ok);
        if (!ok) begin
            check("drop_timeout", 0, 1);
        end else begin
            check("drop_pulses", pulses, 16);
            check("drop_len", len, FRAME_LEN);
            check("drop_valid", vl, 1);
            check("drop_temp", temperature, 13'h0123);
        end
        seen_low = 1'b0;
        repeat (POLL + 500) begin
            @(negedge mclk);
            if (!temp_ncs || busy) seen_low = 1'b1;
        end
        check("drop_idle", seen_low, 0);

        // Reset at bit 9, then a fresh full frame.
        model_temp = 13'h0155;
        model_conv = 1'b1;
        enable = 1'b1;
        guard = 0;
        @(negedge mclk);
        while (temp_ncs && guard < 100) begin guard++; @(negedge mclk); end
        fallcnt = 0;
        prev = 1'b1;
        while (fallcnt < 9 && guard < 1000) begin
            if (prev && !temp_clk) fallcnt++;
            prev = temp_clk;
            guard++;
            if (fallcnt < 9) @(negedge mclk);
        end
        check("rst_reached_bit9", fallcnt, 9);
        rst = 1'b1;
        #1;
        check("mid_rst_ncs", temp_ncs, 1);
        check("mid_rst_clk", temp_clk, 1);
        check("mid_rst_temp", temperature, 0);
        check("mid_rst_ready", temp_ready, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ot", overtemp, 0);
        @(negedge mclk);
        rst = 1'b0;
        model_temp = 13'h0100;
        run_frame(0, hi, pulses, len, ve, vl, bm, ok);
        if (!ok) begin
            check("post_rst_timeout", 0, 1);
        end else begin
            check("post_rst_start", hi, 0);
            check("post_rst_pulses", pulses, 16);
            check("post_rst_valid", vl, 1);
            check("post_rst_temp", temperature, 13'h0100);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
